// File: rtl/core_inst_seq.sv
`default_nettype none
// core_inst_seq: steps each kernel position through weight fetch, PE load, settle and execute/drain.
// Optional CORE_INST_SEQ_STATS_EN adds busy-cycle and issued-row counters.
module core_inst_seq #(
  parameter int col       = 8,
  parameter int row       = 8,
  parameter int len_nij   = 36,
  parameter int num_kij   = 9,
  parameter int gap_cyc   = 10,
  parameter int w_base    = 1024,
  parameter int drain_max = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
`ifdef CORE_INST_SEQ_STATS_EN
  ,
  output logic [31:0] stat_cycles,
  output logic [15:0] stat_rows
`endif
);

  localparam logic [33:0] INST_IDLE = 34'h1800C0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WL0   = 3'd1,
    S_WLOAD = 3'd2,
    S_GAP   = 3'd3,
    S_EXEC  = 3'd4,
    S_DRAIN = 3'd5,
    S_NEXT  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] kij, kij_nxt;
  logic [15:0] wr_cnt, wr_cnt_nxt;
  logic        holdoff;
  logic        rd_fire;
  logic [33:0] inst_nxt;
  logic        busy_nxt, done_nxt, err_nxt;
  logic [10:0] xaddr, paddr;

  assign xaddr = 11'(w_base + int'(kij) * col + int'(cnt));
  assign paddr = 11'(int'(kij) * len_nij + int'(wr_cnt));

  // holdoff masks the cycle where ofifo_valid still reflects the row just read
  assign rd_fire = ((state == S_EXEC) || (state == S_DRAIN)) && ofifo_valid &&
                   !holdoff && (wr_cnt < 16'(len_nij));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    kij_nxt    = kij;
    wr_cnt_nxt = wr_cnt + (rd_fire ? 16'd1 : 16'd0);
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    err_nxt    = err_timeout;
    inst_nxt   = INST_IDLE;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_WL0;
          cnt_nxt    = '0;
          kij_nxt    = '0;
          wr_cnt_nxt = '0;
          err_nxt    = 1'b0;
          busy_nxt   = 1'b1;
        end
      end
      S_WL0: begin
        inst_nxt[19]   = 1'b0;
        inst_nxt[17:7] = xaddr;
        inst_nxt[2]    = 1'b1;
        if (cnt == 16'(col - 1)) begin
          state_nxt = S_WLOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_WLOAD: begin
        inst_nxt[3] = 1'b1;
        inst_nxt[0] = 1'b1;
        if (cnt == 16'(col + row - 1)) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt == 16'(gap_cyc - 1)) begin
          state_nxt = S_EXEC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_EXEC: begin
        inst_nxt[19]   = 1'b0;
        inst_nxt[17:7] = 11'(cnt);
        inst_nxt[3]    = 1'b1;
        inst_nxt[2]    = 1'b1;
        inst_nxt[1]    = 1'b1;
        if (cnt == 16'(len_nij - 1)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_DRAIN: begin
        if (wr_cnt == 16'(len_nij)) begin
          state_nxt = S_NEXT;
        end else if (cnt == 16'(drain_max - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_NEXT;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_NEXT: begin
        cnt_nxt = '0;
        if (kij == 16'(num_kij - 1)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt  = S_WL0;
          kij_nxt    = kij + 16'd1;
          wr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // psum write rides alongside whatever xmem/L0 activity the phase issues
    if (rd_fire) begin
      inst_nxt[32]    = 1'b0;
      inst_nxt[31]    = 1'b0;
      inst_nxt[30:20] = paddr;
      inst_nxt[6]     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      kij         <= '0;
      wr_cnt      <= '0;
      holdoff     <= 1'b0;
      inst        <= INST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      kij         <= kij_nxt;
      wr_cnt      <= wr_cnt_nxt;
      holdoff     <= rd_fire;
      inst        <= inst_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err_timeout <= err_nxt;
    end
  end

`ifdef CORE_INST_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cycles <= '0;
      stat_rows   <= '0;
    end else if ((state == S_IDLE) && start) begin
      stat_cycles <= '0;
      stat_rows   <= '0;
    end else begin
      if (busy)    stat_cycles <= stat_cycles + 32'd1;
      if (rd_fire) stat_rows   <= stat_rows + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_inst_seq.sv
`default_nettype none
// tb_core_inst_seq: positional reference model of the instruction stream, driven with directed and random ofifo_valid.
module tb_core_inst_seq;
  localparam int COL = 8, ROW = 8, LEN = 36, GAP = 10, WB = 1024, DMAX = 64;
  localparam int E0 = COL + COL + ROW + GAP;  // first execute position
  localparam int D0 = E0 + LEN;               // first drain position
  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  logic clk, reset, start9, start1, ofv;
  logic [33:0] inst9, inst1;
  logic busy9, busy1, done9, done1, err9, err1;
`ifdef CORE_INST_SEQ_STATS_EN
  logic [31:0] sc9, sc1;
  logic [15:0] sr9, sr1;
`endif

  core_inst_seq #(.num_kij(9)) u9 (
    .clk(clk), .reset(reset), .start(start9), .ofifo_valid(ofv),
    .inst(inst9), .busy(busy9), .done(done9), .err_timeout(err9)
`ifdef CORE_INST_SEQ_STATS_EN
    , .stat_cycles(sc9), .stat_rows(sr9)
`endif
  );
  core_inst_seq #(.num_kij(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .ofifo_valid(ofv),
    .inst(inst1), .busy(busy1), .done(done1), .err_timeout(err1)
`ifdef CORE_INST_SEQ_STATS_EN
    , .stat_cycles(sc1), .stat_rows(sr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit sel;
  logic [33:0] o_inst;
  logic o_busy, o_done, o_err;
  assign o_inst = sel ? inst1 : inst9;
  assign o_busy = sel ? busy1 : busy9;
  assign o_done = sel ? done1 : done9;
  assign o_err  = sel ? err1 : err9;

  int total = 0, bad = 0, now = 0;
  int hits[2048];
  int nreads, busy_len;

  task automatic cyc();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Instruction expected at kij k, position p, ignoring the psum-write fields.
  function automatic logic [33:0] ctrl_word(input int k, input int p, input bit nxt);
    logic [33:0] w;
    w = IDLE_W;
    if (!nxt) begin
      if (p < COL) begin
        w[19] = 1'b0; w[17:7] = 11'(WB + k * COL + p); w[2] = 1'b1;
      end else if (p < COL + COL + ROW) begin
        w[3] = 1'b1; w[0] = 1'b1;
      end else if (p >= E0 && p < D0) begin
        w[19] = 1'b0; w[17:7] = 11'(p - E0); w[3] = 1'b1; w[2] = 1'b1; w[1] = 1'b1;
      end
    end
    return w;
  endfunction

  // mode: 0 valid high, 1 rows ready 16 cycles after execute, 2 random, 3 valid low
  task automatic run(input int nk, input int mode, input bit repulse, input int abort_p);
    int k, p, rd, guard, rows, read_n;
    bit hold, fire, v, fin, nxt, err_exp, aborted;
    logic [33:0] ew;
    logic eb, ed;
    int ready[$];
    sel = (nk == 1);
    for (int i = 0; i < 2048; i++) hits[i] = 0;
    nreads = 0; busy_len = 0;
    if (sel) start1 = 1'b1; else start9 = 1'b1;
    cyc();
    start1 = 1'b0; start9 = 1'b0;
    check("start", {28'd0, o_inst, o_busy, o_done}, {28'd0, IDLE_W, 1'b1, 1'b0});
    check("err_clr", {63'd0, o_err}, 64'd0);
    if (o_busy) busy_len++;
    v = (mode == 0) || (mode == 2 && $urandom_range(0, 3) != 0);
    ofv = v;
    k = 0; p = 0; rd = 0; hold = 0; fin = 0; nxt = 0; err_exp = 0; aborted = 0;
    guard = 0; rows = 0; read_n = 0;
    while (!fin && guard < 20000) begin
      guard++;
      if (!nxt && k == 0 && p == abort_p) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort", {28'd0, o_inst, o_busy, o_done}, {28'd0, IDLE_W, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
          cyc();
          check("post_abort", {28'd0, o_inst, o_busy, o_done}, {28'd0, IDLE_W, 1'b0, 1'b0});
        end
        aborted = 1; fin = 1;
      end else begin
        ew = ctrl_word(k, p, nxt);
        fire = !nxt && p >= E0 && v && !hold && rd < LEN;
        if (fire) begin
          ew[32] = 1'b0; ew[31] = 1'b0; ew[30:20] = 11'(k * LEN + rd); ew[6] = 1'b1;
        end
        eb = 1'b1; ed = 1'b0;
        if (nxt && k == nk - 1) begin eb = 1'b0; ed = 1'b1; fin = 1; end
        if (repulse && !nxt && k == 0 && p == E0 + 6) begin
          if (sel) start1 = 1'b1; else start9 = 1'b1;
        end
        cyc();
        start1 = 1'b0; start9 = 1'b0;
        check($sformatf("seq k%0d p%0d", k, p), {28'd0, o_inst, o_busy, o_done}, {28'd0, ew, eb, ed});
        if (o_busy) busy_len++;
        if (o_inst[6]) begin hits[o_inst[30:20]]++; nreads++; read_n++; end
        if (nxt) begin
          nxt = 0; k++; p = 0; rd = 0; hold = 0;
        end else begin
          hold = fire;
          if (p >= D0 && rd == LEN) nxt = 1;
          else if (p == D0 + DMAX - 1) begin nxt = 1; err_exp = 1; end
          else p++;
          if (fire) rd++;
        end
        if (mode == 1 && o_inst[1]) ready.push_back(now + 16);
        while (ready.size() > 0 && ready[0] <= now) begin
          void'(ready.pop_front());
          rows++;
        end
        case (mode)
          0: v = 1'b1;
          1: v = rows > read_n;
          2: v = ($urandom_range(0, 3) != 0);
          default: v = 1'b0;
        endcase
        ofv = v;
      end
    end
    if (!fin) check("timeout_guard", 64'd0, 64'd1);
    ofv = 1'b0;
    if (!aborted) begin
      check("err", {63'd0, o_err}, {63'd0, err_exp});
      cyc();
      check("after_done", {28'd0, o_inst, o_busy, o_done}, {28'd0, IDLE_W, 1'b0, 1'b0});
      if (mode == 0 || mode == 1) check("nreads", 64'(nreads), 64'(nk * LEN));
      if (mode == 3) check("nreads_none", 64'(nreads), 64'd0);
`ifdef CORE_INST_SEQ_STATS_EN
      if (sel) begin
        check("stat_rows", 64'(sr1), 64'(nreads));
        check("stat_cycles", 64'(sc1), 64'(busy_len));
      end
`endif
    end
  endtask

  initial begin
    int badaddr;
    reset = 1'b1; start9 = 1'b0; start1 = 1'b0; ofv = 1'b0; sel = 0;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle9", {28'd0, inst9, busy9, done9}, {28'd0, IDLE_W, 1'b0, 1'b0});
      check("idle1", {28'd0, inst1, busy1, done1, err1}, {27'd0, IDLE_W, 3'b000});
    end

    run(1, 0, 1'b1, -1);
    run(9, 1, 1'b0, -1);
    badaddr = 0;
    for (int a = 0; a < 2048; a++)
      if (hits[a] != ((a < 9 * LEN) ? 1 : 0)) badaddr++;
    check("psum_cover", 64'(badaddr), 64'd0);

    run(1, 3, 1'b0, -1);
    run(1, 0, 1'b0, -1);
    run(9, 2, 1'b0, -1);
    run(9, 0, 1'b0, COL + 4);
    run(1, 2, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
